// File: rtl/lc3_mmio_ctrl.sv
// LC-3 memory-mapped I/O controller: keyboard KBSR/KBDR over a receive FIFO,
// display DSR/DDR over a one-byte handshake, plus registered IRQ/INTP/INTV.
module lc3_mmio_ctrl #(
   parameter int unsigned KB_DEPTH = 4,
   parameter logic [2:0]  KB_PRI   = 3'd4,
   parameter logic [2:0]  DSP_PRI  = 3'd4,
   parameter logic [7:0]  KB_VEC   = 8'h80,
   parameter logic [7:0]  DSP_VEC  = 8'h81
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] mmio_addr,
   input  logic [15:0] mmio_wdata,
   input  logic        mmio_ld,
   input  logic        mmio_rd,
   output logic [15:0] mmio_rdata,
   input  logic [7:0]  kb_data,
   input  logic        kb_valid,
   output logic        kb_ready,
   output logic [7:0]  dsp_data,
   output logic        dsp_valid,
   input  logic        dsp_ready,
   output logic        irq,
   output logic [2:0]  intp,
   output logic [7:0]  intv
);

   localparam int unsigned PTR_W = $clog2(KB_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [15:0] ADDR_KBSR = 16'hFE00;
   localparam logic [15:0] ADDR_KBDR = 16'hFE02;
   localparam logic [15:0] ADDR_DSR  = 16'hFE04;
   localparam logic [15:0] ADDR_DDR  = 16'hFE06;

   typedef enum logic {
      S_IDLE,
      S_BUSY
   } dsp_state_t;

   logic [7:0]       mem [KB_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             kie;
   logic             die;
   dsp_state_t       state;
   dsp_state_t       state_next;

   logic fifo_nonempty;
   logic push;
   logic pop;
   logic ddr_wr;
   logic kb_req;
   logic dsp_req;
   logic unused_wdata;

   assign unused_wdata  = ^{mmio_wdata[15], mmio_wdata[13:8]};

   assign fifo_nonempty = (count != '0);
   assign kb_ready      = (count != CNT_W'(KB_DEPTH));
   assign push          = kb_valid && kb_ready;
   assign pop           = mmio_rd && (mmio_addr == ADDR_KBDR) && fifo_nonempty;
   assign ddr_wr        = mmio_ld && (mmio_addr == ADDR_DDR);

   assign dsp_valid     = (state == S_BUSY);
   assign kb_req        = fifo_nonempty && kie;
   assign dsp_req       = (state == S_IDLE) && die;

   always_comb begin
      mmio_rdata = '0;
      case (mmio_addr)
         ADDR_KBSR: mmio_rdata = {fifo_nonempty, kie, 14'h0000};
         ADDR_KBDR: if (fifo_nonempty) mmio_rdata = {8'h00, mem[rd_ptr]};
         ADDR_DSR:  mmio_rdata = {(state == S_IDLE), die, 14'h0000};
         default:   mmio_rdata = '0;
      endcase
   end

   // Storage needs no reset; the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= kb_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         kie <= 1'b0;
         die <= 1'b0;
      end else if (mmio_ld) begin
         if (mmio_addr == ADDR_KBSR) kie <= mmio_wdata[14];
         if (mmio_addr == ADDR_DSR)  die <= mmio_wdata[14];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (ddr_wr)    state_next = S_BUSY;
         S_BUSY:  if (dsp_ready) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)                              dsp_data <= 8'h00;
      else if (state == S_IDLE && ddr_wr)   dsp_data <= mmio_wdata[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         irq  <= 1'b0;
         intp <= 3'd0;
         intv <= 8'h00;
      end else begin
         irq <= kb_req || dsp_req;
         if (kb_req) begin
            intp <= KB_PRI;
            intv <= KB_VEC;
         end else if (dsp_req) begin
            intp <= DSP_PRI;
            intv <= DSP_VEC;
         end else begin
            intp <= 3'd0;
            intv <= 8'h00;
         end
      end
   end

endmodule

// File: tb/tb_lc3_mmio_ctrl.sv
// Self-checking bench for lc3_mmio_ctrl: directed scenarios plus a randomized
// run compared against a queue-based behavioural model.
module tb_lc3_mmio_ctrl;

   logic        clk;
   logic        rst;
   logic [15:0] mmio_addr;
   logic [15:0] mmio_wdata;
   logic        mmio_ld;
   logic        mmio_rd;
   logic [15:0] mmio_rdata;
   logic [7:0]  kb_data;
   logic        kb_valid;
   logic        kb_ready;
   logic [7:0]  dsp_data;
   logic        dsp_valid;
   logic        dsp_ready;
   logic        irq;
   logic [2:0]  intp;
   logic [7:0]  intv;

   int total = 0;
   int bad   = 0;

   lc3_mmio_ctrl #(
      .KB_DEPTH(4),
      .KB_PRI  (3'd4),
      .DSP_PRI (3'd4),
      .KB_VEC  (8'h80),
      .DSP_VEC (8'h81)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mmio_addr (mmio_addr),
      .mmio_wdata(mmio_wdata),
      .mmio_ld   (mmio_ld),
      .mmio_rd   (mmio_rd),
      .mmio_rdata(mmio_rdata),
      .kb_data   (kb_data),
      .kb_valid  (kb_valid),
      .kb_ready  (kb_ready),
      .dsp_data  (dsp_data),
      .dsp_valid (dsp_valid),
      .dsp_ready (dsp_ready),
      .irq       (irq),
      .intp      (intp),
      .intv      (intv)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [7:0] q[$];
   logic       m_kie, m_die, m_busy;
   logic [7:0] m_dbyte;
   logic       m_irq;
   logic [2:0] m_intp;
   logic [7:0] m_intv;

   function automatic logic [15:0] model_read(input logic [15:0] a);
      case (a)
         16'hFE00: return {(q.size() != 0), m_kie, 14'h0};
         16'hFE02: return (q.size() != 0) ? {8'h00, q[0]} : 16'h0000;
         16'hFE04: return {!m_busy, m_die, 14'h0};
         default:  return 16'h0000;
      endcase
   endfunction

   task automatic idle_inputs();
      rst = 0; mmio_ld = 0; mmio_rd = 0; kb_valid = 0; dsp_ready = 0;
      mmio_addr = 16'h0000; mmio_wdata = 16'h0000; kb_data = 8'h00;
   endtask

   // Advance one clock edge and update the model from the inputs applied before it.
   task automatic step();
      logic        r, ld, rd, kv, dr, kreq, dreq, do_pop, do_push;
      logic [15:0] a, wd;
      logic [7:0]  kd;
      r = rst; ld = mmio_ld; rd = mmio_rd; kv = kb_valid; dr = dsp_ready;
      a = mmio_addr; wd = mmio_wdata; kd = kb_data;
      kreq    = (q.size() != 0) && m_kie;
      dreq    = !m_busy && m_die;
      do_pop  = rd && (a == 16'hFE02) && (q.size() != 0);
      do_push = kv && (q.size() < 4);
      @(posedge clk); #1;
      if (r) begin
         q.delete();
         m_kie = 0; m_die = 0; m_busy = 0; m_dbyte = 8'h00;
         m_irq = 0; m_intp = 3'd0; m_intv = 8'h00;
      end else begin
         if (do_pop)  void'(q.pop_front());
         if (do_push) q.push_back(kd);
         if (ld && a == 16'hFE00) m_kie = wd[14];
         if (ld && a == 16'hFE04) m_die = wd[14];
         if (m_busy) begin
            if (dr) m_busy = 0;
         end else if (ld && a == 16'hFE06) begin
            m_busy  = 1;
            m_dbyte = wd[7:0];
         end
         m_irq  = kreq | dreq;
         m_intp = kreq ? 3'd4 : (dreq ? 3'd4 : 3'd0);
         m_intv = kreq ? 8'h80 : (dreq ? 8'h81 : 8'h00);
      end
   endtask

   task automatic test_reset();
      logic [15:0] exp_rd [4];
      exp_rd = '{16'h0000, 16'h0000, 16'h8000, 16'h0000};
      idle_inputs();
      rst = 1;
      step();
      rst = 0;
      for (int i = 0; i < 4; i++) begin
         mmio_addr = 16'hFE00 + 16'(2 * i);
         #1;
         total++;
         if (mmio_rdata !== exp_rd[i]) begin
            bad++;
            $display("FAIL reset_read addr=%h got=%h exp=%h", mmio_addr, mmio_rdata, exp_rd[i]);
         end
      end
      total++;
      if ({kb_ready, dsp_valid, irq, intp, intv} !== {1'b1, 1'b0, 1'b0, 3'd0, 8'h00}) begin
         bad++;
         $display("FAIL reset_flags got kb_ready=%b dsp_valid=%b irq=%b intp=%0d intv=%h exp 1 0 0 0 00",
                  kb_ready, dsp_valid, irq, intp, intv);
      end
   endtask

   task automatic test_fifo_fill();
      idle_inputs();
      kb_valid = 1;
      for (int i = 0; i < 4; i++) begin
         kb_data = 8'h41 + 8'(i);
         step();
      end
      total++;
      if (kb_ready !== 1'b0) begin
         bad++;
         $display("FAIL fifo_full_ready got=%b exp=0", kb_ready);
      end
      kb_data = 8'h45;
      step();
      kb_valid = 0;
      mmio_rd = 1;
      mmio_addr = 16'hFE02;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++;
         if (mmio_rdata !== {8'h00, 8'h41 + 8'(i)}) begin
            bad++;
            $display("FAIL fifo_pop%0d got=%h exp=%h", i, mmio_rdata, {8'h00, 8'h41 + 8'(i)});
         end
         step();
      end
      mmio_rd = 0;
      mmio_addr = 16'hFE00;
      #1;
      total++;
      if (mmio_rdata !== 16'h0000) begin
         bad++;
         $display("FAIL fifo_empty_kbsr got=%h exp=0000", mmio_rdata);
      end
   endtask

   task automatic test_push_pop();
      logic [7:0] exp_b [2];
      idle_inputs();
      kb_valid = 1;
      kb_data = 8'h10; step();
      kb_data = 8'h11; step();
      kb_data = 8'h55;
      mmio_rd = 1;
      mmio_addr = 16'hFE02;
      #1;
      total++;
      if (mmio_rdata !== 16'h0010) begin
         bad++;
         $display("FAIL pushpop_head got=%h exp=0010", mmio_rdata);
      end
      step();
      kb_valid = 0;
      mmio_rd = 0;
      total++;
      if (q.size() != 2 || mmio_rdata !== 16'h0011) begin
         bad++;
         $display("FAIL pushpop_occupancy model_size=%0d got_head=%h exp=0011", q.size(), mmio_rdata);
      end
      exp_b = '{8'h11, 8'h55};
      mmio_rd = 1;
      for (int i = 0; i < 2; i++) begin
         #1;
         total++;
         if (mmio_rdata !== {8'h00, exp_b[i]}) begin
            bad++;
            $display("FAIL pushpop_drain%0d got=%h exp=%h", i, mmio_rdata, {8'h00, exp_b[i]});
         end
         step();
      end
      mmio_rd = 0;
      mmio_addr = 16'hFE00;
      #1;
      total++;
      if (mmio_rdata !== 16'h0000) begin
         bad++;
         $display("FAIL pushpop_empty got=%h exp=0000", mmio_rdata);
      end
   endtask

   task automatic test_display();
      idle_inputs();
      mmio_ld = 1; mmio_addr = 16'hFE06; mmio_wdata = 16'h0058;
      step();
      mmio_ld = 0; mmio_addr = 16'hFE04;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if (dsp_valid !== 1'b1 || dsp_data !== 8'h58 || mmio_rdata !== 16'h0000) begin
            bad++;
            $display("FAIL dsp_busy%0d got valid=%b data=%h dsr=%h exp 1 58 0000",
                     i, dsp_valid, dsp_data, mmio_rdata);
         end
         step();
      end
      mmio_ld = 1; mmio_addr = 16'hFE06; mmio_wdata = 16'h0059;
      step();
      mmio_ld = 0; mmio_addr = 16'hFE04;
      #1;
      total++;
      if (dsp_data !== 8'h58 || dsp_valid !== 1'b1) begin
         bad++;
         $display("FAIL dsp_drop got data=%h valid=%b exp 58 1", dsp_data, dsp_valid);
      end
      dsp_ready = 1;
      step();
      dsp_ready = 0;
      total++;
      if (mmio_rdata !== 16'h8000 || dsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL dsp_done got dsr=%h valid=%b exp 8000 0", mmio_rdata, dsp_valid);
      end
   endtask

   task automatic test_irq();
      idle_inputs();
      kb_valid = 1; kb_data = 8'h7A;
      step();
      kb_valid = 0;
      mmio_ld = 1; mmio_addr = 16'hFE00; mmio_wdata = 16'h4000; step();
      mmio_addr = 16'hFE04; step();
      mmio_ld = 0;
      step();
      total++;
      if ({irq, intp, intv} !== {1'b1, 3'd4, 8'h80}) begin
         bad++;
         $display("FAIL irq_kb got irq=%b intp=%0d intv=%h exp 1 4 80", irq, intp, intv);
      end
      mmio_rd = 1; mmio_addr = 16'hFE02;
      step();
      mmio_rd = 0;
      total++;
      if (intv !== 8'h80) begin
         bad++;
         $display("FAIL irq_pop_lag got intv=%h exp=80", intv);
      end
      step();
      total++;
      if ({irq, intp, intv} !== {1'b1, 3'd4, 8'h81}) begin
         bad++;
         $display("FAIL irq_dsp got irq=%b intp=%0d intv=%h exp 1 4 81", irq, intp, intv);
      end
      mmio_ld = 1; mmio_addr = 16'hFE04; mmio_wdata = 16'h0000;
      step();
      mmio_ld = 0;
      step();
      total++;
      if ({irq, intp, intv} !== {1'b0, 3'd0, 8'h00}) begin
         bad++;
         $display("FAIL irq_clear got irq=%b intp=%0d intv=%h exp 0 0 00", irq, intp, intv);
      end
      mmio_ld = 1; mmio_addr = 16'hFE00;
      step();
      mmio_ld = 0;
   endtask

   task automatic test_random();
      logic [15:0] addrs [5];
      addrs = '{16'hFE00, 16'hFE02, 16'hFE04, 16'hFE06, 16'h3000};
      idle_inputs();
      for (int n = 0; n < 400; n++) begin
         rst        = ($urandom_range(0, 99) == 0);
         mmio_addr  = addrs[$urandom_range(0, 4)];
         if (mmio_addr == 16'h3000) mmio_addr = 16'($urandom);
         mmio_wdata = 16'($urandom);
         mmio_ld    = ($urandom_range(0, 3) == 0);
         mmio_rd    = ($urandom_range(0, 1) == 0);
         kb_valid   = ($urandom_range(0, 1) == 0);
         kb_data    = 8'($urandom);
         dsp_ready  = ($urandom_range(0, 2) == 0);
         #1;
         total++;
         if (mmio_rdata !== model_read(mmio_addr)) begin
            bad++;
            $display("FAIL rand_rdata n=%0d addr=%h got=%h exp=%h", n, mmio_addr, mmio_rdata, model_read(mmio_addr));
         end
         step();
         total++;
         if (kb_ready !== (q.size() < 4) || dsp_valid !== m_busy || dsp_data !== m_dbyte ||
             irq !== m_irq || intp !== m_intp || intv !== m_intv) begin
            bad++;
            $display("FAIL rand_outputs n=%0d got rdy=%b v=%b d=%h irq=%b p=%0d v=%h exp rdy=%b v=%b d=%h irq=%b p=%0d v=%h",
                     n, kb_ready, dsp_valid, dsp_data, irq, intp, intv,
                     (q.size() < 4), m_busy, m_dbyte, m_irq, m_intp, m_intv);
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset_midflight();
      idle_inputs();
      rst = 1; step(); rst = 0;
      kb_valid = 1;
      for (int i = 0; i < 4; i++) begin
         kb_data = 8'(8'hA0 + i);
         step();
      end
      kb_valid = 0;
      mmio_ld = 1; mmio_addr = 16'hFE00; mmio_wdata = 16'h4000; step();
      mmio_addr = 16'hFE06; mmio_wdata = 16'h00C3; step();
      mmio_ld = 0;
      step();
      total++;
      if (kb_ready !== 1'b0 || dsp_valid !== 1'b1 || irq !== 1'b1) begin
         bad++;
         $display("FAIL midflight_setup got rdy=%b valid=%b irq=%b exp 0 1 1", kb_ready, dsp_valid, irq);
      end
      rst = 1; kb_valid = 1; kb_data = 8'hFF; mmio_rd = 1; mmio_addr = 16'hFE02; dsp_ready = 1;
      step();
      idle_inputs();
      mmio_addr = 16'hFE00;
      #1;
      total++;
      if ({kb_ready, dsp_valid, dsp_data, irq, intp, intv, mmio_rdata} !==
          {1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00, 16'h0000}) begin
         bad++;
         $display("FAIL midflight_reset got rdy=%b v=%b d=%h irq=%b p=%0d v=%h kbsr=%h",
                  kb_ready, dsp_valid, dsp_data, irq, intp, intv, mmio_rdata);
      end
      mmio_addr = 16'hFE04;
      #1;
      total++;
      if (mmio_rdata !== 16'h8000) begin
         bad++;
         $display("FAIL midflight_dsr got=%h exp=8000", mmio_rdata);
      end
   endtask

   initial begin
      q.delete();
      m_kie = 0; m_die = 0; m_busy = 0; m_dbyte = 8'h00;
      m_irq = 0; m_intp = 3'd0; m_intv = 8'h00;
      idle_inputs();
      test_reset();
      test_fifo_fill();
      test_push_pop();
      test_display();
      test_irq();
      test_random();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
